insn_synth: RTL
===============

# insn_synth

Instruction synthesizer: the encode-side counterpart of the decoder's immediate generator. It accepts a request of `{kind, rd, imm32}` and emits a stream of one or two RV32I instruction words that materialize the constant or perform the jump. It sits in front of the fetch/issue path and serves as a macro-op expander for `li`, `j`/`jal` and `call`/`tail`. Output uses a valid/ready handshake and is fully registered.

## Interface
- No parameters.
- `clk` in 1: clock; all state updates on posedge.
- `rst` in 1: synchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted when `req_valid && req_ready`.
- `req_kind` in 1: `SYN_LI`=0, `SYN_JUMP`=1.
- `req_rd` in 5: destination/link register.
- `req_imm` in 32: constant (LI) or pc-relative byte offset (JUMP).
- `out_valid` out 1: instruction word present.
- `out_ready` in 1: consumer takes the beat when `out_valid && out_ready`.
- `out_insn` out 32: encoded instruction.
- `out_last` out 1: the beat is the final one of the current request.
- `out_err` out 1: one-cycle pulse when a request is rejected (see Configuration).

## Operation
- LI forms:
  - When `req_imm` fits in signed 12 bits: single `ADDI rd,x0,imm[11:0]`.
  - Else when `imm[11:0]==0`: single `LUI rd,imm[31:12]`.
  - Else two beats: `LUI rd,hi` then `ADDI rd,rd,lo`.
    - `lo` = `imm[11:0]`, sign-extended.
    - `hi` = `(imm + 32'h800) >> 12`, computed as a 32-bit modular add.
    - The wrap at the top of the range is legal; for example, `0x7FFFF800` gives `hi=0x80000`.
- JUMP forms:
  - `req_imm[0]` is treated as 0.
  - When the offset fits signed 21 bits: single `JAL rd,off`.
  - Else the far form applies (see Configuration): `AUIPC t,hi` then `JALR rd,lo(t)`.
    - `hi` and `lo` are split as in LI.
    - `t` = `rd`, except `t` = x6 when `rd==x0`.
- Encodings: ADDI 0x13/f3=0, LUI 0x37, AUIPC 0x17, JAL 0x6F, JALR 0x67/f3=0.
- FSM states:
  - IDLE: no request held.
  - BEAT1: first or only word presented.
  - BEAT2: second word presented.
- FSM transitions:
  - IDLE → BEAT1 on accept.
  - BEAT1 → BEAT2 on a transfer when the form has 2 beats.
  - BEAT1 → IDLE, or BEAT1 → BEAT1 (back-to-back accept), on transfer of the last beat.
  - BEAT2 → IDLE, or BEAT2 → BEAT1 (back-to-back accept), on transfer.
- `req_ready` = `(state==IDLE) || (out_valid && out_ready && out_last)`. This allows zero-bubble back-to-back requests.
- The request fields are captured in a register at accept; later changes on `req_*` have no effect.

## Timing
- Reset values: state IDLE, `out_valid`=0, `out_insn`=0, `out_last`=0, `out_err`=0.
- `req_ready`=1 in the first cycle after reset is released.
- Latency: accept at edge N puts the first word on `out_*` from cycle N+1.
- The second word follows in the cycle after the first word transfers.
- While `out_valid && !out_ready`, `out_insn` and `out_last` hold stable.
- `out_valid` never drops without a transfer.
- Accept and last-beat transfer in the same cycle: the new request's first word appears in the next cycle with no gap.
- Reset asserted mid-request: the pending beat is discarded. Outputs take reset values at the next edge and the request is not replayed.
- Rejected request (see Configuration): `out_err`=1 for exactly one cycle at N+1, `out_valid` stays 0, and the FSM returns to IDLE.

## Configuration
- `INSN_SYNTH_FAR_JUMP_EN` defined:
  - An out-of-range JUMP expands to AUIPC+JALR.
  - `out_err` is tied to 0.
- `INSN_SYNTH_FAR_JUMP_EN` undefined:
  - An out-of-range JUMP is accepted, emits no word, and pulses `out_err`.
  - In-range JUMP and all LI requests are unaffected.

## Structure
- Shared package `Common`:
  - `SynKind` enum (`SYN_LI`, `SYN_JUMP`).
  - Opcode constants; reuse the existing `Opcode` values and add `Addi`/`Lui`/`Auipc` where missing.
  - Register constant `REG_T1`=6.
- One combinational sub-module, `insn_pack`:
  - Inputs: format (I/U/J), opcode, rd, rs1, funct3, imm.
  - Output: the 32-bit word.
  - It is the exact inverse of the decoder's field slicing.
- FSM, range checks and hi/lo split live in `insn_synth`.

## Test plan
- LI rd=x5, imm=42 → one beat `0x02A00293`, `out_last`=1.
- LI rd=x5, imm=`0x12345FFF` → `0x123462B7` then `0xFFF28293`; `out_last` is 0 on the first beat and 1 on the second.
- LI rd=x1, imm=`0x00010000` → single `0x000100B7`; LI imm=`0x7FFFF800` → `LUI hi=0x80000`, `ADDI lo=-2048`.
- JUMP rd=x1, imm=`0x800` → single `0x001000EF`.
- JUMP rd=x0, imm=`0x00100000`:
  - Macro on → `0x00100317` then `0x00030067`.
  - Macro off → no beat, `out_err` pulse at N+1.
- Backpressure and reset:
  - Hold `out_ready`=0 for 3 cycles on BEAT2 → word stable; the next request is accepted in the transfer cycle with no bubble.
  - Assert `rst` during BEAT1 → `out_valid`=0 next cycle and no residual beat.

Source files
------------

// File: rtl/insn_synth_pkg.sv
// Shared definitions for the instruction synthesizer: request kinds, instruction
// formats, FSM states, RV32I opcode constants and the encoder field bundle.
package insn_synth_pkg;

  typedef enum logic {
    SYN_LI   = 1'b0,
    SYN_JUMP = 1'b1
  } syn_kind_e;

  typedef enum logic [1:0] {
    FMT_I,
    FMT_U,
    FMT_J
  } insn_fmt_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BEAT1,
    ST_BEAT2
  } syn_state_e;

  localparam logic [6:0] OP_ADDI  = 7'h13;
  localparam logic [6:0] OP_LUI   = 7'h37;
  localparam logic [6:0] OP_AUIPC = 7'h17;
  localparam logic [6:0] OP_JAL   = 7'h6F;
  localparam logic [6:0] OP_JALR  = 7'h67;

  localparam logic [2:0] F3_ZERO  = 3'b000;
  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_T1   = 5'd6;

  typedef struct packed {
    insn_fmt_e   fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [2:0]  funct3;
    logic [31:0] imm;
  } pack_fields_t;

  // True when v is representable as a signed integer of 'bits' bits.
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned bits);
    logic [31:0] s;
    s = 32'($signed(v) >>> (bits - 1));
    return (s == '0) || (s == '1);
  endfunction

endpackage

// File: rtl/insn_pack.sv
// Combinational RV32I word packer for I/U/J formats; places each field exactly
// where the decoder's immediate generator slices it back out.
module insn_pack
  import insn_synth_pkg::*;
(
  input  insn_fmt_e   fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [2:0]  funct3,
  input  logic [31:0] imm,
  output logic [31:0] insn
);

  // Bit 0 of a J-type offset is implicit and never encoded.
  logic unused_imm_lsb;
  assign unused_imm_lsb = imm[0];

  // NOTE: a combinational block assigns every output before any branch, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    insn = '0;
    case (fmt)
      FMT_I:   insn = {imm[11:0], rs1, funct3, rd, opcode};
      FMT_U:   insn = {imm[31:12], rd, opcode};
      FMT_J:   insn = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default: insn = '0;
    endcase
  end

endmodule

// File: rtl/insn_synth.sv
// Macro-op expander for li / j / jal / call / tail into one or two RV32I words.
// Define INSN_SYNTH_FAR_JUMP_EN to expand out-of-range jumps to AUIPC+JALR.
module insn_synth
  import insn_synth_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_kind,
  input  logic [4:0]  req_rd,
  input  logic [31:0] req_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_insn,
  output logic        out_last,
  output logic        out_err
);

  syn_state_e   state, state_next;
  logic [31:0]  insn_next, second_q;
  logic         last_next, err_next;

  logic         is_jump, accept, xfer;
  logic [31:0]  val;
  logic [19:0]  hi;
  logic [11:0]  unused_hi_low;
  logic         fits12, fits21, lo_zero;

  pack_fields_t first_f, second_f;
  logic [31:0]  first_word, second_word;
  logic         form_two, form_err;

  assign out_valid = (state != ST_IDLE);
  assign xfer      = out_valid && out_ready;
  assign req_ready = (state == ST_IDLE) || (xfer && out_last);
  assign accept    = req_valid && req_ready;

  // The form is decided from the live request at accept; the resulting words are
  // registered, so later changes on req_* cannot disturb an in-flight request.
  assign is_jump = (syn_kind_e'(req_kind) == SYN_JUMP);
  assign val     = is_jump ? {req_imm[31:1], 1'b0} : req_imm;
  // Rounding add makes hi compensate for the sign-extended low 12 bits.
  assign {hi, unused_hi_low} = val + 32'h0000_0800;
  assign fits12  = fits_signed(val, 12);
  assign fits21  = fits_signed(val, 21);
  assign lo_zero = (val[11:0] == 12'h000);

`ifdef INSN_SYNTH_FAR_JUMP_EN
  logic [4:0] link_tmp;
  // x0 cannot hold the AUIPC result, so t1 carries the upper part instead.
  assign link_tmp = (req_rd == REG_ZERO) ? REG_T1 : req_rd;
`endif

  always_comb begin
    first_f  = '{fmt: FMT_I, opcode: OP_ADDI, rd: req_rd, rs1: REG_ZERO,
                 funct3: F3_ZERO, imm: val};
    second_f = first_f;
    form_two = 1'b0;
    form_err = 1'b0;
    if (!is_jump) begin
      if (!fits12) begin
        first_f.fmt    = FMT_U;
        first_f.opcode = OP_LUI;
        if (!lo_zero) begin
          first_f.imm  = {hi, 12'h000};
          second_f.rs1 = req_rd;
          form_two     = 1'b1;
        end
      end
    end else if (fits21) begin
      first_f.fmt    = FMT_J;
      first_f.opcode = OP_JAL;
    end else begin
`ifdef INSN_SYNTH_FAR_JUMP_EN
      first_f.fmt     = FMT_U;
      first_f.opcode  = OP_AUIPC;
      first_f.rd      = link_tmp;
      first_f.imm     = {hi, 12'h000};
      second_f.opcode = OP_JALR;
      second_f.rs1    = link_tmp;
      form_two        = 1'b1;
`else
      form_err = 1'b1;
`endif
    end
  end

  insn_pack u_pack_first (
    .fmt    (first_f.fmt),
    .opcode (first_f.opcode),
    .rd     (first_f.rd),
    .rs1    (first_f.rs1),
    .funct3 (first_f.funct3),
    .imm    (first_f.imm),
    .insn   (first_word)
  );

  insn_pack u_pack_second (
    .fmt    (second_f.fmt),
    .opcode (second_f.opcode),
    .rd     (second_f.rd),
    .rs1    (second_f.rs1),
    .funct3 (second_f.funct3),
    .imm    (second_f.imm),
    .insn   (second_word)
  );

  always_comb begin
    state_next = state;
    insn_next  = out_insn;
    last_next  = out_last;
    err_next   = 1'b0;
    if (accept) begin
      err_next = form_err;
      if (form_err) begin
        state_next = ST_IDLE;
      end else begin
        state_next = ST_BEAT1;
        insn_next  = first_word;
        last_next  = !form_two;
      end
    end else if (xfer) begin
      if (state == ST_BEAT1 && !out_last) begin
        state_next = ST_BEAT2;
        insn_next  = second_q;
        last_next  = 1'b1;
      end else begin
        state_next = ST_IDLE;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_IDLE;
      out_insn <= '0;
      out_last <= 1'b0;
      out_err  <= 1'b0;
    end else begin
      state    <= state_next;
      out_insn <= insn_next;
      out_last <= last_next;
      out_err  <= err_next;
    end
  end

  // NOTE: the staged second word is data only, read solely after an accept has
  // loaded it, so it carries no reset.
  always_ff @(posedge clk) begin
    if (accept) second_q <= second_word;
  end

endmodule
